// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: architectural C/N/Z flags plus an in-order register-write queue
// with hazard lookup. Optional decode bypass ports are enabled by defining WB_FORWARD_EN.
module alu_writeback #(
    parameter int DEPTH = 2,
    parameter int RA    = 2,
    parameter int DW    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DW-1:0]              result_i,
    input  logic                       carry_i,
    input  logic                       neg_i,
    input  logic                       wr_en_i,
    input  logic                       flag_en_i,
    input  logic [RA-1:0]              dst_i,
    output logic                       rf_we_o,
    output logic [RA-1:0]              rf_waddr_o,
    output logic [DW-1:0]              rf_wdata_o,
    input  logic                       rf_ready_i,
    output logic                       carry_q_o,
    output logic                       neg_q_o,
    output logic                       zero_q_o,
    input  logic [RA-1:0]              hz_addr_i,
    output logic                       hz_hit_o,
`ifdef WB_FORWARD_EN
    output logic                       fwd_valid_o,
    output logic [DW-1:0]              fwd_data_o,
`endif
    output logic [$clog2(DEPTH):0]     pend_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic is_zero(input logic [DW-1:0] value);
        return (value == {DW{1'b0}});
    endfunction

    logic [RA-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          carry_r;
    logic          neg_r;
    logic          zero_r;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          hz_hit_s;
`ifdef WB_FORWARD_EN
    logic [DW-1:0] fwd_data_s;
`endif

    assign ready_o    = (count_r != CW'(DEPTH));
    assign rf_we_o    = (count_r != {CW{1'b0}});
    assign accept_s   = valid_i & ready_o;
    assign push_s     = accept_s & wr_en_i;
    assign pop_s      = rf_we_o & rf_ready_i;
    assign rf_waddr_o = addr_mem_r[head_r];
    assign rf_wdata_o = data_mem_r[head_r];
    assign carry_q_o  = carry_r;
    assign neg_q_o    = neg_r;
    assign zero_q_o   = zero_r;
    assign pend_o     = count_r;
    assign hz_hit_o   = hz_hit_s;
`ifdef WB_FORWARD_EN
    assign fwd_valid_o = hz_hit_s;
    assign fwd_data_o  = fwd_data_s;
`endif

    // Occupancy update from push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1'b1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Hazard lookup walks from head (oldest) to tail so the last match is the youngest entry.
    always_comb begin
        hz_hit_s = 1'b0;
`ifdef WB_FORWARD_EN
        fwd_data_s = {DW{1'b0}};
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_r) && (addr_mem_r[head_r + PW'(k)] == hz_addr_i)) begin
                hz_hit_s = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_data_s = data_mem_r[head_r + PW'(k)];
`endif
            end else begin
                hz_hit_s = hz_hit_s;
            end
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {RA{1'b0}};
                data_mem_r[i] <= {DW{1'b0}};
            end
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= dst_i;
                data_mem_r[tail_r] <= result_i;
                tail_r             <= tail_r + PW'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Architectural flags, updated in program order by accepted flag-writing beats.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            carry_r <= 1'b0;
            neg_r   <= 1'b0;
            zero_r  <= 1'b1;
        end else if (accept_s && flag_en_i) begin
            carry_r <= carry_i;
            neg_r   <= neg_i;
            zero_r  <= is_zero(result_i);
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios then random traffic against a
// queue-based reference model of the writeback stage.
module tb_alu_writeback;

    localparam int DEPTH = 2;
    localparam int RA    = 2;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic [DW-1:0] result = 8'h00;
    logic          carry = 1'b0;
    logic          neg = 1'b0;
    logic          wr_en = 1'b0;
    logic          flag_en = 1'b0;
    logic [RA-1:0] dst = 2'd0;
    logic          rf_we;
    logic [RA-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_ready = 1'b0;
    logic          carry_q;
    logic          neg_q;
    logic          zero_q;
    logic [RA-1:0] hz_addr = 2'd0;
    logic          hz_hit;
    logic [$clog2(DEPTH):0] pend;
`ifdef WB_FORWARD_EN
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
`endif

    alu_writeback #(.DEPTH(DEPTH), .RA(RA), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(ready),
        .result_i(result), .carry_i(carry), .neg_i(neg), .wr_en_i(wr_en),
        .flag_en_i(flag_en), .dst_i(dst), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
        .rf_wdata_o(rf_wdata), .rf_ready_i(rf_ready), .carry_q_o(carry_q),
        .neg_q_o(neg_q), .zero_q_o(zero_q), .hz_addr_i(hz_addr), .hz_hit_o(hz_hit),
`ifdef WB_FORWARD_EN
        .fwd_valid_o(fwd_valid), .fwd_data_o(fwd_data),
`endif
        .pend_o(pend)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of pending {addr,data} writes plus the flag triple.
    logic [RA+DW-1:0] q[$];
    logic m_c = 1'b0;
    logic m_n = 1'b0;
    logic m_z = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic model_hit(input logic [RA-1:0] a);
        logic h = 1'b0;
        foreach (q[i]) if (q[i][DW+:RA] == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DW-1:0] model_fwd(input logic [RA-1:0] a);
        logic [DW-1:0] d = 8'h00;
        foreach (q[i]) if (q[i][DW+:RA] == a) d = q[i][DW-1:0];
        return d;
    endfunction

    // One clock: check every output against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic acc;
        logic pop;
        logic [RA+DW-1:0] entry;
        @(negedge clk);
        chk("ready", ready, (q.size() != DEPTH));
        chk("rf_we", rf_we, (q.size() != 0));
        chk("pend", pend, q.size());
        if (q.size() != 0) begin
            entry = q[0];
            chk("rf_waddr", rf_waddr, entry[DW+:RA]);
            chk("rf_wdata", rf_wdata, entry[DW-1:0]);
        end
        chk("flags", {carry_q, neg_q, zero_q}, {m_c, m_n, m_z});
        chk("hz_hit", hz_hit, model_hit(hz_addr));
`ifdef WB_FORWARD_EN
        chk("fwd_valid", fwd_valid, model_hit(hz_addr));
        if (model_hit(hz_addr)) chk("fwd_data", fwd_data, model_fwd(hz_addr));
`endif
        acc = valid && (q.size() < DEPTH);
        pop = (q.size() > 0) && rf_ready;
        entry = {dst, result};
        if (acc && flag_en) begin
            m_c = carry;
            m_n = neg;
            m_z = (result == 8'h00);
        end
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && wr_en) q.push_back(entry);
    endtask

    task automatic beat(input logic [DW-1:0] r, input logic [RA-1:0] d, input logic c,
                        input logic n, input logic we, input logic fe);
        valid = 1'b1; result = r; dst = d; carry = c; neg = n; wr_en = we; flag_en = fe;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pend", pend, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_flags", {carry_q, neg_q, zero_q}, 3'b001);
        chk("rst_ready", ready, 1);
        @(posedge clk);
        #1;

        // Zero result with carry: flags and single-cycle queue latency.
        beat(8'h00, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        valid = 1'b0;
        chk("t2_carry", carry_q, 1);
        chk("t2_zero", zero_q, 1);
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 2);
        chk("t2_wdata", rf_wdata, 8'h00);
        rf_ready = 1'b1;
        cycle();
        rf_ready = 1'b0;

        // Fill while the register file stalls, then drain in order.
        beat(8'h11, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        beat(8'h22, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        valid = 1'b0;
        chk("t3_ready_full", ready, 0);
        chk("t3_pend_full", pend, 2);
        rf_ready = 1'b1;
        cycle();
        chk("t3_ready_after_pop", ready, 1);
        chk("t3_second_addr", rf_waddr, 3);
        chk("t3_second_data", rf_wdata, 8'h22);
        cycle();
        rf_ready = 1'b0;
        cycle();

        // Hazard query against a queued write.
        beat(8'h5A, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        valid = 1'b0;
        hz_addr = 2'd2;
        #1;
        chk("t4_hit", hz_hit, 1);
`ifdef WB_FORWARD_EN
        chk("t4_fwd", fwd_data, 8'h5A);
`endif
        hz_addr = 2'd0;
        #1;
        chk("t4_miss", hz_hit, 0);

        // Push and pop together with one entry queued.
        beat(8'h33, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rf_ready = 1'b1;
        cycle();
        valid = 1'b0;
        rf_ready = 1'b0;
        chk("t5_pend", pend, 1);
        chk("t5_addr", rf_waddr, 0);
        chk("t5_data", rf_wdata, 8'h33);

        // Write-only beat leaves flags alone.
        beat(8'h80, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        valid = 1'b0;
        chk("t6_flags", {carry_q, neg_q, zero_q}, 3'b101);
        chk("t6_pend", pend, 2);

        // Asynchronous reset with two entries queued.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_pend", pend, 0);
        chk("t1_rf_we", rf_we, 0);
        chk("t1_zero", zero_q, 1);
        chk("t1_ready", ready, 1);
        q.delete();
        m_c = 1'b0; m_n = 1'b0; m_z = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            valid    = $urandom_range(0, 1);
            result   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            carry    = $urandom_range(0, 1);
            neg      = $urandom_range(0, 1);
            wr_en    = ($urandom_range(0, 3) != 0);
            flag_en  = $urandom_range(0, 1);
            dst      = 2'($urandom);
            rf_ready = $urandom_range(0, 1);
            hz_addr  = 2'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
